// File: rtl/tick_irq_unit_if.sv
// Configuration, tick and interrupt signals of tick_irq_unit.
// master: the CPU / timer side, slave: the tick_irq_unit itself.
interface tick_irq_unit_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   tick;
  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [COUNT_WIDTH-1:0] cfg_wdata;
  logic [COUNT_WIDTH-1:0] cfg_rdata;
  logic                   irq;
  logic                   irq_ack;
  logic                   overrun;

  modport master (
    output tick, cfg_we, cfg_addr, cfg_wdata, irq_ack,
    input  cfg_rdata, irq, overrun
  );

  modport slave (
    input  tick, cfg_we, cfg_addr, cfg_wdata, irq_ack,
    output cfg_rdata, irq, overrun
  );
endinterface

// File: rtl/tick_irq_unit.sv
// Tick counter with programmable compare, saturating pending-event counter
// and level interrupt request with acknowledge handshake.
module tick_irq_unit #(
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned PENDING_WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  tick_irq_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_COMPARE = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_PENDING = 2'd3;

  logic                     tick_q;
  logic [COUNT_WIDTH-1:0]   count_q,   count_d;
  logic [COUNT_WIDTH-1:0]   compare_q, compare_d;
  logic                     en_q,       en_d;
  logic                     periodic_q, periodic_d;
  logic [PENDING_WIDTH-1:0] pending_q,  pending_d;
  logic                     overrun_q,  overrun_d;
  logic                     irq_q,      irq_d;
  state_t                   state_q,    state_d;

  logic tick_edge;
  logic wr_ctrl;
  logic wr_compare;
  logic clr;
  logic evt;
  logic ack_dec;

  assign tick_edge  = bus.tick & ~tick_q;
  assign wr_ctrl    = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);
  assign wr_compare = bus.cfg_we && (bus.cfg_addr == ADDR_COMPARE);
  assign clr        = wr_ctrl && bus.cfg_wdata[2];
  // Ack only decrements a non-empty counter, so a CLR during ASSERT cannot underflow.
  assign ack_dec    = (state_q == ST_ASSERT) && bus.irq_ack && (pending_q != '0);

  // Tick counting, compare match and CTRL/COMPARE register writes.
  always_comb begin
    count_d    = count_q;
    compare_d  = compare_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    evt        = 1'b0;
    if (wr_compare) begin
      // A COMPARE write restarts the count and swallows a coincident tick.
      compare_d = bus.cfg_wdata;
      count_d   = '0;
    end else if (tick_edge && en_q) begin
      if ((compare_q == '0) || (count_q >= compare_q - COUNT_WIDTH'(1))) begin
        count_d = '0;
        evt     = 1'b1;
        if (!periodic_q) begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
    // The tick above saw the old CTRL; a CTRL write wins for the next state.
    if (wr_ctrl) begin
      en_d       = bus.cfg_wdata[0];
      periodic_d = bus.cfg_wdata[1];
    end
  end

  // Saturating pending counter and sticky overrun flag; CLR overrides all.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clr) begin
      pending_d = '0;
      overrun_d = 1'b0;
    end else if (evt && !ack_dec) begin
      if (pending_q == '1) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = pending_q + PENDING_WIDTH'(1);
      end
    end else if (ack_dec && !evt) begin
      pending_d = pending_q - PENDING_WIDTH'(1);
    end
  end

  // Interrupt handshake next state; irq is registered from the next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (pending_q != '0) state_d = ST_ASSERT;
      ST_ASSERT:  if (bus.irq_ack)     state_d = ST_RELEASE;
      ST_RELEASE: if (!bus.irq_ack)    state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_ASSERT);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q     <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      pending_q  <= '0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      tick_q     <= bus.tick;
      count_q    <= count_d;
      compare_q  <= compare_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    bus.cfg_rdata = '0;
    unique case (bus.cfg_addr)
      ADDR_CTRL:    bus.cfg_rdata = COUNT_WIDTH'({overrun_q, 1'b0, periodic_q, en_q});
      ADDR_COMPARE: bus.cfg_rdata = compare_q;
      ADDR_COUNT:   bus.cfg_rdata = count_q;
      ADDR_PENDING: bus.cfg_rdata = COUNT_WIDTH'(pending_q);
      default:      bus.cfg_rdata = '0;
    endcase
  end

  assign bus.irq     = irq_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_tick_irq_unit.sv
// Bench for tick_irq_unit: register table, irq-rise scoreboard, corner sequences.
module tb_tick_irq_unit;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset;
  logic man_ack;
  logic auto_en;
  logic auto_ack_q = 1'b0;
  int   ackwait = 0;
  int   cyc = 0;
  logic irq_prev = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_q[$];

  tick_irq_unit_if #(.COUNT_WIDTH(CW)) bus();

  assign bus.irq_ack = auto_en ? auto_ack_q : man_ack;

  tick_irq_unit #(.COUNT_WIDTH(CW), .PENDING_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record the cycle of every irq rising edge.
  always @(negedge clock) begin
    if (bus.irq && !irq_prev) obs_q.push_back(cyc);
    irq_prev <= bus.irq;
  end

  // CPU model: raise ack two cycles after irq, drop it once irq falls.
  always @(negedge clock) begin
    if (!auto_en) begin
      auto_ack_q <= 1'b0;
      ackwait    <= 0;
    end else if (bus.irq && !auto_ack_q) begin
      if (ackwait == 1) auto_ack_q <= 1'b1;
      else              ackwait    <= ackwait + 1;
    end else if (!bus.irq) begin
      auto_ack_q <= 1'b0;
      ackwait    <= 0;
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  raddr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic check_reg(input string nm, input logic [1:0] a, input logic [15:0] exp);
    bus.cfg_addr = a;
    #1;
    check(nm, bus.cfg_rdata, exp);
  endtask

  task automatic pulse_tick(input bit expect_evt, input int gap);
    if (expect_evt) exp_q.push_back(cyc + 2);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step(gap);
  endtask

  task automatic sb_check(input string nm);
    int e, o;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({nm, "_irq_rise_cycle"}, o, e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_irq_missing: got none expected rise at cycle %0d", nm, e);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_irq_unexpected: got rise at cycle %0d expected none", nm, o);
    end
  endtask

  task automatic do_reset();
    bus.tick   = 1'b0;
    bus.cfg_we = 1'b0;
    man_ack    = 1'b0;
    auto_en    = 1'b0;
    reset      = 1'b1;
    step(2);
    reset      = 1'b0;
    step();
  endtask

  initial begin
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = '0;
    man_ack       = 1'b0;
    auto_en       = 1'b0;

    vecs[0] = '{"ctrl_bit3_ignored", 2'd0, 16'h000B, 2'd0, 16'h0003};
    vecs[1] = '{"ctrl_clr_reads0",   2'd0, 16'h0007, 2'd0, 16'h0003};
    vecs[2] = '{"compare_rw",        2'd1, 16'hBEEF, 2'd1, 16'hBEEF};
    vecs[3] = '{"count_readonly",    2'd2, 16'h1234, 2'd2, 16'h0000};
    vecs[4] = '{"pending_readonly",  2'd3, 16'h0005, 2'd3, 16'h0000};
    vecs[5] = '{"ctrl_periodic",     2'd0, 16'h0002, 2'd0, 16'h0002};
    vecs[6] = '{"ctrl_off",          2'd0, 16'h0000, 2'd0, 16'h0000};
    vecs[7] = '{"compare_zero",      2'd1, 16'h0000, 2'd1, 16'h0000};

    // Reset state
    do_reset();
    check_reg("rst_ctrl", 2'd0, 16'h0);
    check_reg("rst_compare", 2'd1, 16'h0);
    check_reg("rst_count", 2'd2, 16'h0);
    check_reg("rst_pending", 2'd3, 16'h0);
    check("rst_irq", bus.irq, 0);
    check("rst_overrun", bus.overrun, 0);

    // Register access table
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      check_reg(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end
    sb_check("regs");

    // Periodic: COMPARE=3, 9 ticks -> irq after ticks 3, 6, 9
    do_reset();
    wr(2'd1, 16'd3);
    wr(2'd0, 16'h3);
    auto_en = 1'b1;
    for (int t = 1; t <= 9; t++) pulse_tick((t % 3) == 0, 7);
    check_reg("per_count", 2'd2, 16'h0);
    check_reg("per_pending", 2'd3, 16'h0);
    check("per_overrun", bus.overrun, 0);
    check("per_irq_low", bus.irq, 0);
    sb_check("periodic");

    // Long tick level: one event only
    do_reset();
    wr(2'd1, 16'd1);
    wr(2'd0, 16'h3);
    exp_q.push_back(cyc + 2);
    bus.tick = 1'b1;
    step(5);
    bus.tick = 1'b0;
    step(2);
    check_reg("long_pending", 2'd3, 16'h1);
    check("long_irq", bus.irq, 1);
    man_ack = 1'b1;
    step();
    check("long_irq_ackd", bus.irq, 0);
    check_reg("long_pending_ackd", 2'd3, 16'h0);
    man_ack = 1'b0;
    step(3);
    check("long_irq_stays_low", bus.irq, 0);
    sb_check("long");

    // One-shot: COMPARE=2, CTRL=1, 4 ticks
    do_reset();
    wr(2'd1, 16'd2);
    wr(2'd0, 16'h1);
    auto_en = 1'b1;
    pulse_tick(1'b0, 7);
    check_reg("os_count_t1", 2'd2, 16'h1);
    pulse_tick(1'b1, 7);
    pulse_tick(1'b0, 7);
    pulse_tick(1'b0, 7);
    check_reg("os_ctrl", 2'd0, 16'h0);
    check_reg("os_count", 2'd2, 16'h0);
    sb_check("oneshot");

    // Saturation and CLR, including CLR while irq is asserted
    do_reset();
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h3);
    pulse_tick(1'b1, 1);
    for (int t = 2; t <= 17; t++) pulse_tick(1'b0, 1);
    check_reg("sat_pending", 2'd3, 16'd15);
    check("sat_overrun", bus.overrun, 1);
    check_reg("sat_ctrl", 2'd0, 16'h000B);
    wr(2'd0, 16'h4);
    check_reg("clr_pending", 2'd3, 16'h0);
    check("clr_overrun", bus.overrun, 0);
    check_reg("clr_ctrl", 2'd0, 16'h0);
    check("clr_irq_held", bus.irq, 1);
    man_ack = 1'b1;
    step();
    check("clr_irq_ackd", bus.irq, 0);
    check_reg("clr_no_underflow", 2'd3, 16'h0);
    man_ack = 1'b0;
    step(3);
    check("clr_irq_stays_low", bus.irq, 0);
    sb_check("sat");

    // Event and ack in the same cycle
    do_reset();
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h3);
    pulse_tick(1'b1, 1);
    pulse_tick(1'b0, 1);
    check_reg("sim_pending_pre", 2'd3, 16'd2);
    check("sim_irq_pre", bus.irq, 1);
    bus.tick = 1'b1;
    man_ack  = 1'b1;
    step();
    bus.tick = 1'b0;
    check_reg("sim_pending", 2'd3, 16'd2);
    check("sim_irq_release", bus.irq, 0);
    step();
    check("sim_irq_release2", bus.irq, 0);
    exp_q.push_back(cyc + 2);
    man_ack = 1'b0;
    step(3);
    check("sim_irq_reassert", bus.irq, 1);
    sb_check("sim");

    // Asynchronous reset while irq=1 and pending=3
    pulse_tick(1'b0, 1);
    check_reg("mid_pending_pre", 2'd3, 16'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_irq_now", bus.irq, 0);
    check_reg("mid_pending", 2'd3, 16'h0);
    check_reg("mid_count", 2'd2, 16'h0);
    check_reg("mid_ctrl", 2'd0, 16'h0);
    step();
    reset = 1'b0;
    step();
    pulse_tick(1'b0, 2);
    pulse_tick(1'b0, 2);
    check("mid_no_irq", bus.irq, 0);
    check_reg("mid_pending_post", 2'd3, 16'h0);
    wr(2'd0, 16'h3);
    pulse_tick(1'b1, 3);
    check("mid_irq_new", bus.irq, 1);
    sb_check("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_irq_unit.md
Name: tick_irq_unit

Overview:
- Downstream consumer of the periodic tick pulse produced by the system timer.
- Counts ticks against a programmable compare value and queues timer events in a saturating pending counter.
- Presents events to the CPU core as a level interrupt request with an acknowledge handshake.
- Programmed by the CPU through a small four-register configuration port.

Parameters:
- COUNT_WIDTH, 16, width of the tick counter, the COMPARE register and the cfg data bus.
- PENDING_WIDTH, 4, width of the saturating pending-event counter (max 2^PENDING_WIDTH-1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  timer pulse; a 0->1 transition counts as one tick; high level may last several cycles.
- cfg_we  input  1  configuration write strobe, sampled on the rising clock edge.
- cfg_addr  input  2  register select: 0 CTRL, 1 COMPARE, 2 COUNT, 3 PENDING.
- cfg_wdata  input  COUNT_WIDTH  write data.
- cfg_rdata  output  COUNT_WIDTH  combinational read data for cfg_addr.
- irq  output  1  interrupt request to the CPU.
- irq_ack  input  1  interrupt acknowledge from the CPU.
- overrun  output  1  sticky flag: an event was lost because the pending counter was saturated.

Behaviour:
- Reset: count, COMPARE, CTRL, pending and the tick_q edge register are all 0; irq=0; overrun=0; FSM=IDLE.
- Tick detect: tick_edge = tick & ~tick_q; tick_q <= tick every cycle.
- CTRL register:
  - bit0 EN.
  - bit1 PERIODIC.
  - bit2 CLR: write-1, self-clearing, always reads 0; clears pending and overrun.
  - bit3 reads overrun; writes to bit3 are ignored.
- Counting: on tick_edge with EN=1:
  - If count >= COMPARE-1, or COMPARE==0: count <= 0 and an event is generated.
  - Otherwise count <= count+1.
  - Ticks with EN=0 are ignored; count holds.
- One-shot mode (PERIODIC=0): the edge that generates an event also clears EN.
- Writing COMPARE also forces count to 0. A tick_edge in the same cycle is discarded.
- Writing CTRL takes effect at that edge. A tick_edge in the same cycle is evaluated with the old CTRL value.
- COUNT and PENDING are read-only; writes to them are ignored.
- Pending counter update at the clock edge:
  - event and no ack-decrement: +1.
  - ack-decrement and no event: -1.
  - both: unchanged.
  - Increment at saturation: pending holds and overrun <= 1.
  - CLR has priority over every pending and overrun update in the same cycle.
- Interrupt FSM:
  - IDLE: irq=0. If pending>0, go to ASSERT.
  - ASSERT: irq=1. If irq_ack=1, pending decrements and the FSM goes to RELEASE.
  - RELEASE: irq=0. Stays until irq_ack=0, then goes to IDLE.
  - irq is registered and reflects the current state.
- Latency:
  - tick_edge sampled at edge k produces an event; pending becomes 1 at edge k.
  - irq rises at edge k+1.
  - irq falls at the edge that samples irq_ack=1.
  - Minimum gap between two irq pulses: one RELEASE cycle plus one IDLE cycle.
- CLR while in ASSERT: pending becomes 0, but irq stays high until acked. The ack decrement saturates at 0 and does not underflow.
- cfg_rdata values:
  - addr 0: {overrun, 0, PERIODIC, EN}, zero-extended.
  - addr 1: COMPARE.
  - addr 2: count.
  - addr 3: pending, zero-extended.
- Reset mid-operation: everything returns immediately to its reset value, including a high irq.

Test Plan:
- Periodic count: COMPARE=3, CTRL=3, 9 single-cycle ticks, ack 2 cycles after each irq -> exactly 3 irq pulses, after ticks 3, 6 and 9; COUNT reads 0 at the end; overrun=0.
- Long tick level: tick held high 5 cycles, COMPARE=1, EN=1 -> exactly one event; pending=1; irq rises one cycle after the rising tick.
- One-shot: COMPARE=2, CTRL=1, 4 ticks -> one event after tick 2; CTRL reads 0 afterwards; ticks 3 and 4 leave COUNT=0.
- Saturation: PENDING_WIDTH=4, COMPARE=0, EN=1, 17 ticks with no ack -> pending=15, overrun=1, CTRL reads bit3 set; write CTRL=0x4 -> pending=0, overrun=0.
- Simultaneous event and ack: pending=2 and irq high; ack arrives in the same cycle an event is generated -> pending stays 2; FSM goes to RELEASE, then IDLE; irq re-asserts.
- Async reset asserted while irq=1 and pending=3 -> irq, pending, count and CTRL all read 0 immediately; no irq after reset deasserts until new ticks arrive with EN set.
